shift_right_seq: RTL
====================

# shift_right_seq

Multi-cycle right shifter for the execute stage, complementing the combinational left-shift used for immediate/branch-offset scaling. It performs SRL/SRA and the RV64 word forms SRLW/SRAW on a 64-bit operand, shifting up to STEP bit positions per cycle under a start/busy/done handshake. The hazard unit stalls the pipeline while busy is high. The final value is captured into the EX/MEM register on the done pulse.

## Interface
- XLEN, 64: operand/result width; only 64 is supported.
- STEP, 4: maximum bit positions shifted per cycle; must be a power of 2, 1..32.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when not busy.
- arith  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- word  in  1  1 = W-form: operate on data_in[31:0], result sign-extended from bit 31.
- data_in  in  64  operand, sampled with start.
- shamt  in  6  shift amount, sampled with start; only shamt[4:0] is used when word=1.
- busy  out  1  high while a shift is in progress.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  64  final value; held until the next accepted start.

## Operation
- FSM states:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1, held for exactly one cycle.
- Accept: start=1 in IDLE or DONE at a rising edge.
  - Latch opreg, n, fill and mode flags.
  - Next state is SHIFT if n≠0, DONE if n=0.
- Operand load when word=1:
  - opreg = arith ? sext(data_in[31:0]) : zext(data_in[31:0]).
  - n = shamt[4:0].
- Operand load when word=0: opreg = data_in, n = shamt.
- Fill bit = arith & opreg[63], evaluated on the loaded operand.
- SHIFT, each edge:
  - s = min(STEP, n).
  - opreg = (opreg >> s), with the vacated upper s bits set to the fill bit.
  - n -= s.
  - When n reaches 0, go to DONE.
- DONE:
  - Result register = word ? sext(opreg[31:0]) : opreg.
  - Next state is IDLE, or accept a new start (back-to-back).
- start while in SHIFT is ignored: no queueing, no effect on the shift in progress.
- data_in, shamt, arith and word are don't-care except on accepted start edges.

## Timing
- Reset (reset=0 at an edge):
  - State goes to IDLE; busy=0, done=0, result=0, n=0.
  - This holds even mid-SHIFT; the partial result is discarded and done is not pulsed.
- Latency, with start accepted at edge E0:
  - done is high in the cycle after edge E0+k, where k = ceil(n/STEP).
  - shamt=0: done in the cycle immediately after E0.
  - STEP=4, shamt=63: k=16; busy is high for 16 cycles, then done for 1.
- result changes only on entry to DONE (registered output) and is stable from the done cycle until the next DONE.
- Throughput: start asserted in the DONE cycle is accepted; with shamt=0 this gives a new done every cycle.
- start and reset together: reset wins.

## Structure
- Shared package/include shift_pkg:
  - FSM state encodings: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - Default STEP.
  - Localparam for the shamt width, $clog2(XLEN).
- Sub-module shift_right_step: combinational right shift by s∈[0,STEP] with fill-bit input, instantiated once inside the SHIFT datapath.

## Test plan
- SRL, data_in=0x8000_0000_0000_0000, shamt=63, STEP=4 -> busy for 16 cycles, done in cycle 17, result=0x0000_0000_0000_0001.
- SRA, data_in=0xFFFF_FFFF_FFFF_FFF0, shamt=4 -> done in cycle 2, result=0xFFFF_FFFF_FFFF_FFFF.
- SRAW, data_in=0x1234_5678_8000_0000, shamt=0x24 (low 5 bits = 4) -> result=0xFFFF_FFFF_F800_0000; SRLW with the same inputs -> 0x0000_0000_0800_0000.
- shamt=0, back-to-back starts held high for 3 cycles with different data -> three consecutive done pulses, each result equals the corresponding data_in.
- start pulsed again during SHIFT with different data -> ignored; the first operation's result and latency are unchanged.
- reset=0 at cycle 5 of a 63-bit shift -> next cycle busy=0, done=0, result=0, and no done pulse follows.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle right shifter.
// FSM encodings, default step size and shift-amount width.
package shift_pkg;

    localparam int XLEN_DEF = 64;
    localparam int STEP_DEF = 4;
    localparam int SHAMT_W  = $clog2(XLEN_DEF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One iteration of the right shifter.
// Shifts by s in [0,STEP] and fills vacated bits with fill.
module shift_right_step #(
    parameter int XLEN = 64,
    parameter int STEP = 4,
    parameter int SW   = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] din,
    input  logic [SW-1:0]   s,
    input  logic            fill,
    output logic [XLEN-1:0] dout
);

    logic [XLEN-1:0] ones;
    logic [XLEN-1:0] mask;

    // Logical shift, then OR the fill bit into the vacated top bits
    always_comb begin
        ones = '1;
        mask = ~(ones >> s);
        dout = (din >> s) | (fill ? mask : '0);
    end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA/SRLW/SRAW for the execute stage.
// Shifts up to STEP bits per cycle under start/busy/done.
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int STEP = STEP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               arith,
    input  logic               word,
    input  logic [XLEN-1:0]    data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    localparam int SW = $clog2(STEP + 1);
    localparam logic [SHAMT_W:0] STEP_N = (SHAMT_W + 1)'(STEP);

    state_t state_q, state_d;

    logic [XLEN-1:0]    opreg_q, opreg_d;
    logic [SHAMT_W-1:0] n_q, n_d;
    logic               fill_q, fill_d;
    logic               word_q, word_d;
    logic [XLEN-1:0]    res_d;

    logic [XLEN-1:0]    ld_op;
    logic [SHAMT_W-1:0] ld_n;
    logic               ld_fill;
    logic               accept;
    logic [SW-1:0]      step_s;
    logic [XLEN-1:0]    step_out;

    shift_right_step #(
        .XLEN (XLEN),
        .STEP (STEP),
        .SW   (SW)
    ) u_step (
        .din  (opreg_q),
        .s    (step_s),
        .fill (fill_q),
        .dout (step_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, datapath next values and status outputs
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        state_d = state_q;
        opreg_d = opreg_q;
        n_d     = n_q;
        fill_d  = fill_q;
        word_d  = word_q;
        res_d   = result;

        if (word) begin
            ld_op = arith ? {{(XLEN-32){data_in[31]}}, data_in[31:0]}
                          : {{(XLEN-32){1'b0}}, data_in[31:0]};
            ld_n  = {1'b0, shamt[4:0]};
        end else begin
            ld_op = data_in;
            ld_n  = shamt;
        end
        ld_fill = arith & ld_op[XLEN-1];

        step_s = ({1'b0, n_q} > STEP_N) ? SW'(STEP) : SW'(n_q);
        accept = start && (state_q != S_SHIFT);

        unique case (state_q)
            S_IDLE:  busy = 1'b0;
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase

        if (accept) begin
            opreg_d = ld_op;
            n_d     = ld_n;
            fill_d  = ld_fill;
            word_d  = word;
            state_d = (ld_n != '0) ? S_SHIFT : S_DONE;
        end else if (state_q == S_SHIFT) begin
            opreg_d = step_out;
            n_d     = n_q - SHAMT_W'(step_s);
            if (n_d == '0) state_d = S_DONE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else begin
            state_d = S_IDLE;
        end

        if (state_d == S_DONE) begin
            res_d = word_d ? {{(XLEN-32){opreg_d[31]}}, opreg_d[31:0]}
                           : opreg_d;
        end
    end

    // Operand, count, flags and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            opreg_q <= '0;
            n_q     <= '0;
            fill_q  <= 1'b0;
            word_q  <= 1'b0;
            result  <= '0;
        end else begin
            opreg_q <= opreg_d;
            n_q     <= n_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            result  <= res_d;
        end
    end

endmodule
